// File: rtl/instruction_fetch_unit.sv
// LEGv8 fetch stage: PC register, instruction memory addressing and IF/ID pipeline register.
// Optional fetch fault checking is compiled in with `define IF_FAULT_CHECK_EN.
module instruction_fetch_unit #(
  parameter logic [63:0] RESET_PC   = 64'd0,
  parameter int          IMEM_BYTES = 226
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [63:0] branch_target,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [63:0] ifid_pc,
  output logic [63:0] ifid_pc_plus4,
  output logic [31:0] ifid_instr,
  output logic        ifid_valid,
  output logic [31:0] fetch_count,
  output logic        fetch_fault
);

  typedef struct packed {
    logic [63:0] pc;
    logic [63:0] pc_plus4;
    logic [31:0] instr;
    logic        valid;
  } ifid_t;

  logic [63:0] pc;
  logic [63:0] pc_plus4;
  ifid_t       ifid;
  logic [31:0] count;
  logic        fault_now;

  assign pc_plus4  = pc + 64'd4;
  assign imem_addr = pc;

`ifdef IF_FAULT_CHECK_EN
  localparam logic [64:0] IMEM_LIMIT = 65'(IMEM_BYTES);
  logic fault_q;

  // Widened so the last-byte check cannot wrap near the top of the address space.
  assign fault_now = (pc[1:0] != 2'b00) || (({1'b0, pc} + 65'd3) >= IMEM_LIMIT);

  always_ff @(posedge clk) begin
    if (reset)
      fault_q <= 1'b0;
    else if (!flush && !branch_taken && !stall && fault_now)
      fault_q <= 1'b1;
  end

  assign fetch_fault = fault_q;
`else
  assign fault_now   = 1'b0;
  assign fetch_fault = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      pc    <= RESET_PC;
      ifid  <= '0;
      count <= '0;
    end else begin
      if (branch_taken)
        pc <= branch_target;
      else if (!stall && !fault_now)
        pc <= pc_plus4;

      // Bubble beats stall so a squashed slot never lingers in IF/ID.
      if (flush || branch_taken) begin
        ifid <= '0;
      end else if (!stall) begin
        if (fault_now) begin
          ifid <= '0;
        end else begin
          ifid.pc       <= pc;
          ifid.pc_plus4 <= pc_plus4;
          ifid.instr    <= imem_data;
          ifid.valid    <= 1'b1;
          if (count != 32'hFFFF_FFFF)
            count <= count + 32'd1;
        end
      end
    end
  end

  assign ifid_pc       = ifid.pc;
  assign ifid_pc_plus4 = ifid.pc_plus4;
  assign ifid_instr    = ifid.instr;
  assign ifid_valid    = ifid.valid;
  assign fetch_count   = count;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: driver pushes model predictions, monitor checks each edge.
module tb_instruction_fetch_unit;

  localparam logic [63:0] RESET_PC   = 64'd0;
  localparam int          IMEM_BYTES = 226;
`ifdef IF_FAULT_CHECK_EN
  localparam bit FAULT_EN = 1'b1;
`else
  localparam bit FAULT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, stall, flush, branch_taken;
  logic [63:0] branch_target;
  logic [63:0] imem_addr;
  logic [31:0] imem_data;
  logic [63:0] ifid_pc, ifid_pc_plus4;
  logic [31:0] ifid_instr;
  logic        ifid_valid;
  logic [31:0] fetch_count;
  logic        fetch_fault;

  instruction_fetch_unit #(.RESET_PC(RESET_PC), .IMEM_BYTES(IMEM_BYTES)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .ifid_pc(ifid_pc), .ifid_pc_plus4(ifid_pc_plus4), .ifid_instr(ifid_instr),
    .ifid_valid(ifid_valid), .fetch_count(fetch_count), .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  // Memory contents as a pure function of the byte address.
  function automatic logic [31:0] imem_word(input logic [63:0] a);
    if (a < 64'd256) begin
      if (a[7:2] == 6'd0) return 32'hF842_8005;
      if (a[7:2] == 6'd1) return 32'hF845_000A;
      return {2'b10, a[7:2], 8'hC3, 2'b01, a[7:2], a[7:2], 2'b11};
    end
    return a[31:0] ^ a[63:32] ^ 32'h5A5A_0F0F;
  endfunction

  assign imem_data = imem_word(imem_addr);

  typedef struct {
    logic [63:0] pc;
    logic [63:0] ipc;
    logic [63:0] ipc4;
    logic [31:0] instr;
    logic        valid;
    logic [31:0] cnt;
    logic        flt;
  } exp_t;

  exp_t q[$];

  // Reference state: what the fetch stage should hold right now.
  logic [63:0] m_pc, m_ipc, m_ipc4;
  logic [31:0] m_instr, m_cnt;
  logic        m_valid, m_flt;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  task automatic step(input logic r, input logic s, input logic f, input logic b,
                      input logic [63:0] t);
    bit   bad_addr;
    exp_t e;
    reset = r; stall = s; flush = f; branch_taken = b; branch_target = t;
    if (r) begin
      m_pc = RESET_PC; m_ipc = 0; m_ipc4 = 0; m_instr = 0; m_valid = 0; m_cnt = 0; m_flt = 0;
    end else begin
      bad_addr = FAULT_EN && ((m_pc % 4) != 0 || m_pc > 64'(IMEM_BYTES - 4));
      if (f || b) begin
        m_ipc = 0; m_ipc4 = 0; m_instr = 0; m_valid = 0;
      end else if (!s) begin
        if (bad_addr) begin
          m_ipc = 0; m_ipc4 = 0; m_instr = 0; m_valid = 0; m_flt = 1;
        end else begin
          m_ipc = m_pc; m_ipc4 = m_pc + 4; m_instr = imem_word(m_pc); m_valid = 1;
          if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
        end
      end
      if (b) m_pc = t;
      else if (!s && !bad_addr) m_pc = m_pc + 4;
    end
    e.pc = m_pc; e.ipc = m_ipc; e.ipc4 = m_ipc4; e.instr = m_instr;
    e.valid = m_valid; e.cnt = m_cnt; e.flt = m_flt;
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
    end
  endtask

  // Monitor: one prediction per clock edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("imem_addr", imem_addr, e.pc);
        chk("ifid_pc", ifid_pc, e.ipc);
        chk("ifid_pc_plus4", ifid_pc_plus4, e.ipc4);
        chk("ifid_instr", 64'(ifid_instr), 64'(e.instr));
        chk("ifid_valid", 64'(ifid_valid), 64'(e.valid));
        chk("fetch_count", 64'(fetch_count), 64'(e.cnt));
        chk("fetch_fault", 64'(fetch_fault), 64'(e.flt));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    logic [63:0] t;
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    // Free run, then stall at PC 8 for two edges, release.
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    // Taken branch at PC 12 to 24, then capture target.
    step(0, 0, 0, 1, 64'd24);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    // Flush together with stall, then branch together with stall.
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 1, 0, 1, 64'd40);
    step(0, 0, 0, 0, 0);
    // Reset overrides stall and branch mid-stream.
    step(1, 1, 1, 1, 64'd100);
    step(0, 0, 0, 0, 0);
    // PC wraps at the top of the address space.
    step(0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    // Misaligned and near-end targets (fault cases when checking is built in).
    step(0, 0, 0, 1, 64'd6);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 64'd0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 64'd224);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 64'd220);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    // Randomized traffic.
    for (int i = 0; i < 500; i++) begin
      k = $urandom_range(0, 9);
      if (k < 6)      t = 64'($urandom_range(0, 60)) << 2;
      else if (k < 8) t = 64'($urandom_range(0, 255));
      else            t = {$urandom, $urandom};
      step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 20,
           $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 12, t);
    end
    reset = 0; stall = 1; flush = 0; branch_taken = 0;
    @(posedge clk);
    #3;
    chk("scoreboard_drained", 64'(q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Fetch stage of the pipelined LEGv8/ARM core. Holds the 64-bit program counter, drives the byte address into the combinational instruction memory, and registers the returned 32-bit word with its PC into the IF/ID pipeline register. Handles stall (hold), flush (bubble) and taken-branch redirect from downstream stages, and counts fetched instructions for debug.

## Interface
- RESET_PC, 64'd0, PC value loaded on reset
- IMEM_BYTES, 226, instruction memory size in bytes; used only by the fault check
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- stall  in  1  hazard unit: hold PC and IF/ID
- flush  in  1  squash IF/ID contents (bubble)
- branch_taken  in  1  redirect PC this cycle
- branch_target  in  64  redirect address
- imem_addr  out  64  byte address to instruction memory (= PC)
- imem_data  in  32  instruction word from memory, combinational on imem_addr
- ifid_pc  out  64  PC of registered instruction
- ifid_pc_plus4  out  64  PC+4 of registered instruction
- ifid_instr  out  32  registered instruction
- ifid_valid  out  1  IF/ID holds a real instruction
- fetch_count  out  32  valid instructions captured since reset
- fetch_fault  out  1  sticky fetch fault (see Configuration)

## Operation
- imem_addr = PC, combinational.
- PC next-state priority: reset → RESET_PC; branch_taken → branch_target; stall → hold; else PC + 4 (mod 2^64, wraps silently).
- IF/ID next-state priority: reset → all zero, valid 0; flush or branch_taken → bubble (pc, pc_plus4, instr = 0, valid 0); stall → hold all fields; else capture {PC, PC+4, imem_data}, valid 1.
- flush and stall together: bubble wins; PC still holds (unless branch_taken).
- branch_taken and stall together: PC takes branch_target, IF/ID bubbled.
- fetch_count increments by 1 on every edge where IF/ID captures with valid 1; saturates at 32'hFFFFFFFF; no increment on hold or bubble.
- Bubble encoding is 32'h00000000; downstream decode treats valid 0 as NOP regardless of instr.

## Timing
- Reset values: PC = RESET_PC, imem_addr = RESET_PC, ifid_* = 0, ifid_valid = 0, fetch_count = 0, fetch_fault = 0.
- Latency: word at PC appears on ifid_instr one edge after PC is presented.
- First edge after reset deasserts captures the word at RESET_PC; PC becomes RESET_PC+4.
- Redirect: branch_taken sampled at edge N → PC = branch_target after N; target word in IF/ID after N+1. One bubble cycle per taken branch.
- Stall for k cycles: PC and IF/ID frozen k cycles; resume with PC+4 on first unstalled edge.
- Reset asserted mid-stream overrides branch/stall/flush on that edge.

## Configuration
- IF_FAULT_CHECK_EN defined: on a would-be capture edge (not reset/flush/branch/stall), if PC[1:0] ≠ 0 or PC + 3 ≥ IMEM_BYTES, IF/ID loads a bubble instead, PC holds, fetch_count does not increment, fetch_fault sets and stays 1 until reset. A subsequent branch_taken still redirects PC; fault flag remains set.
- Undefined: no checks; fetch_fault tied to 0; out-of-range addresses fetch whatever memory returns.

## Test plan
- Reset then 3 free-running edges with word0 = 32'hF8428005, word1 = 32'hF845000A → IF/ID sequence (pc 0, F8428005, valid 1), (pc 4, F845000A), (pc 8); pc_plus4 = pc+4; fetch_count = 3.
- stall high for 2 edges after PC = 8 → PC stays 8, IF/ID holds pc 4 word, fetch_count unchanged; release → captures pc 8.
- branch_taken with target 64'd24 at PC = 12 → IF/ID bubble (valid 0, instr 0), PC = 24; next edge captures pc 24, valid 1.
- flush and stall together at PC = 16 → IF/ID bubble, PC stays 16; branch_taken with stall → PC = target, bubble.
- reset asserted mid-stream with stall and branch_taken high → PC = RESET_PC, all outputs at reset values; PC = 64'hFFFF_FFFF_FFFF_FFFC via branch → next PC wraps to 0.
- IF_FAULT_CHECK_EN defined, branch to 64'd6 → fetch_fault = 1, IF/ID bubble, PC holds 6; branch to 0 → fetch resumes, fault stays 1; branch to 224 (IMEM_BYTES 226) also faults.
